// File: rtl/spi_regctrl_pkg.sv
// SPI slave register controller: shared types and constants.
// Command byte layout and controller state encoding.
package spi_regctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS = 1 << ADDR_W;

  localparam int CMD_RD = 7;
  localparam int CMD_BURST = 6;
  localparam int CMD_CLR = 5;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    HOLD
  } state_t;
endpackage

// File: rtl/spi_regbank.sv
// 8 x 8-bit register bank for the SPI slave controller.
// One write port, one read port for tx loads, reg0 tap for the LEDs.
module spi_regbank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS = 8
) (
  input  logic              sclk_s,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] reg0
);
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge sclk_s) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign reg0 = mem[0];
endmodule

// File: rtl/spi_slave_regctrl.sv
// SPI slave command controller: frames cmd + data bytes per ss_s
// window and sequences reads/writes against the register bank.
module spi_slave_regctrl
  import spi_regctrl_pkg::*;
#(
  parameter int DATA_W = spi_regctrl_pkg::DATA_W,
  parameter int ADDR_W = spi_regctrl_pkg::ADDR_W,
  parameter int NREGS = spi_regctrl_pkg::NREGS
) (
  input  logic       sclk_s,
  input  logic       rst,
  input  logic       ss_s,
  input  logic       miso_s,
  output logic       mosi_s,
  input  logic       sw,
  output logic [3:0] led,
  output logic       busy,
  output logic       frame_err
);
  localparam logic [2:0] LAST = 3'(DATA_W - 1);

  state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [DATA_W-2:0] rx, rx_n;
  logic [DATA_W-1:0] rx_in;
  logic [DATA_W-1:0] tx, tx_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata, reg0;
  logic rd, rd_n;
  logic burst, burst_n;
  logic ferr_n;
  logic we;

  spi_regbank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) u_bank (
    .sclk_s(sclk_s),
    .rst   (rst),
    .we    (we),
    .waddr (addr),
    .wdata (rx_in),
    .raddr (raddr),
    .rdata (rdata),
    .reg0  (reg0)
  );

  assign rx_in = {rx, miso_s};

  always_ff @(posedge sclk_s) begin
    if (!rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx <= '0;
      tx <= '0;
      addr <= '0;
      rd <= 1'b0;
      burst <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      rx <= rx_n;
      tx <= tx_n;
      addr <= addr_n;
      rd <= rd_n;
      burst <= burst_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    rx_n = rx;
    tx_n = tx;
    addr_n = addr;
    rd_n = rd;
    burst_n = burst;
    ferr_n = frame_err;
    we = 1'b0;
    raddr = addr + 1'b1;
    if (ss_s) begin
      // HOLD never counts bits, so only CMD/DATA can leave bit_cnt != 0
      state_n = IDLE;
      bit_cnt_n = '0;
      if (bit_cnt != '0) ferr_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          rx_n = rx_in[DATA_W-2:0];
          bit_cnt_n = 3'd1;
          state_n = CMD;
        end
        CMD: begin
          rx_n = rx_in[DATA_W-2:0];
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == LAST) begin
            rd_n = rx_in[CMD_RD];
            burst_n = rx_in[CMD_BURST];
            addr_n = rx_in[ADDR_W-1:0];
            raddr = rx_in[ADDR_W-1:0];
            if (rx_in[CMD_CLR]) ferr_n = 1'b0;
            if (rx_in[CMD_RD]) tx_n = rdata;
            state_n = DATA;
          end
        end
        DATA: begin
          rx_n = rx_in[DATA_W-2:0];
          tx_n = {tx[DATA_W-2:0], 1'b0};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == LAST) begin
            we = !rd;
            if (burst) begin
              addr_n = addr + 1'b1;
              if (rd) tx_n = rdata;
            end else begin
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          state_n = HOLD;
        end
      endcase
    end
  end

  assign mosi_s = (state == DATA) & rd & tx[DATA_W-1];
  assign busy = (state != IDLE);
  assign led = sw ? reg0[7:4] : reg0[3:0];
endmodule

// File: tb/tb_spi_slave_regctrl.sv
// Self-checking bench for spi_slave_regctrl against a
// byte-level model of frames, register contents and error flag.
module tb_spi_slave_regctrl;
  typedef logic [7:0] bq_t [$];

  logic sclk_s = 1'b0;
  logic rst = 1'b0;
  logic ss_s = 1'b1;
  logic miso_s = 1'b0;
  logic sw = 1'b0;
  logic mosi_s;
  logic [3:0] led;
  logic busy;
  logic frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mreg [8];
  logic mferr;

  always #5 sclk_s = ~sclk_s;

  spi_slave_regctrl dut (
    .sclk_s   (sclk_s),
    .rst      (rst),
    .ss_s     (ss_s),
    .miso_s   (miso_s),
    .mosi_s   (mosi_s),
    .sw       (sw),
    .led      (led),
    .busy     (busy),
    .frame_err(frame_err)
  );

  // Drives one ss_s-low window: whole bytes then `extra` random bits.
  task automatic run_frame(input bq_t bytes, input int extra,
                           input string nm);
    int n;
    int total;
    int a;
    int s;
    int k;
    logic [7:0] cmd;
    logic [7:0] rb;
    logic rd;
    logic burst;
    logic b;
    logic em;
    n = bytes.size();
    cmd = (n > 0) ? bytes[0] : 8'h00;
    rd = cmd[7];
    burst = cmd[6];
    a = int'(cmd[2:0]);
    total = 8 * n + extra;
    for (int e = 1; e <= total; e++) begin
      if (e <= 8 * n) begin
        rb = bytes[(e - 1) / 8];
        b = rb[7 - ((e - 1) % 8)];
      end else begin
        b = 1'($urandom);
      end
      ss_s = 1'b0;
      miso_s = b;
      @(posedge sclk_s);
      @(negedge sclk_s);
      em = 1'b0;
      if (rd && e >= 8) begin
        s = e - 8;
        k = s / 8;
        if (burst || k == 0) begin
          rb = mreg[(a + k) % 8];
          em = rb[7 - (s % 8)];
        end
      end
      checks++;
      if (mosi_s !== em) begin
        errors++;
        $display("FAIL %s mosi edge %0d: got %b want %b",
                 nm, e, mosi_s, em);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy edge %0d: got %b want 1",
                 nm, e, busy);
      end
    end
    for (int j = 1; j < n; j++) begin
      if (!rd && (burst || j == 1)) mreg[(a + j - 1) % 8] = bytes[j];
    end
    if (n > 0 && cmd[5]) mferr = 1'b0;
    if (extra > 0 && (n < 2 || burst)) mferr = 1'b1;
    ss_s = 1'b1;
    miso_s = 1'b0;
    @(posedge sclk_s);
    @(negedge sclk_s);
    checks++;
    if (frame_err !== mferr) begin
      errors++;
      $display("FAIL %s frame_err: got %b want %b",
               nm, frame_err, mferr);
    end
    checks++;
    if (busy !== 1'b0 || mosi_s !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got busy=%b mosi=%b want 0 0",
               nm, busy, mosi_s);
    end
  endtask

  // Reads every register back over SPI; mosi is compared to the model.
  task automatic read_all(input string nm);
    bq_t q;
    logic [7:0] c;
    for (int r = 0; r < 8; r++) begin
      c = 8'h80 | 8'(r);
      q = {c, 8'h00};
      run_frame(q, 0, nm);
    end
  endtask

  task automatic test_reset();
    logic [3:0] el;
    rst = 1'b0;
    ss_s = 1'b1;
    repeat (3) @(posedge sclk_s);
    @(negedge sclk_s);
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mferr = 1'b0;
    checks++;
    if (busy !== 1'b0 || frame_err !== 1'b0 || mosi_s !== 1'b0) begin
      errors++;
      $display("FAIL reset outs: got busy=%b ferr=%b mosi=%b want 0",
               busy, frame_err, mosi_s);
    end
    for (int v = 0; v < 2; v++) begin
      sw = v[0];
      #1;
      el = 4'h0;
      checks++;
      if (led !== el) begin
        errors++;
        $display("FAIL reset led sw=%0d: got %h want %h", v, led, el);
      end
    end
    sw = 1'b0;
    rst = 1'b1;
    @(negedge sclk_s);
    read_all("reset_regs");
  endtask

  task automatic test_write();
    bq_t q;
    q = {8'h02, 8'hA5};
    run_frame(q, 0, "write");
  endtask

  task automatic test_read();
    bq_t q;
    q = {8'h82, 8'h00};
    run_frame(q, 0, "read");
  endtask

  task automatic test_burst_wrap();
    bq_t q;
    logic [3:0] el;
    q = {8'h47, 8'h11, 8'h22};
    run_frame(q, 0, "burst_wrap");
    for (int v = 0; v < 2; v++) begin
      sw = v[0];
      #1;
      el = v[0] ? mreg[0][7:4] : mreg[0][3:0];
      checks++;
      if (led !== el) begin
        errors++;
        $display("FAIL burst_led sw=%0d: got %h want %h", v, led, el);
      end
    end
    sw = 1'b0;
    read_all("burst_regs");
  endtask

  task automatic test_partial();
    bq_t q;
    q.delete();
    run_frame(q, 5, "partial");
    q = {8'h20, 8'h3C};
    run_frame(q, 0, "clr_err");
    read_all("partial_regs");
  endtask

  task automatic test_overrun();
    bq_t q;
    q = {8'h03, 8'h5A, 8'hFF};
    run_frame(q, 0, "overrun");
    read_all("overrun_regs");
  endtask

  task automatic test_reset_mid();
    bq_t q;
    logic [7:0] cmd;
    logic [7:0] dat;
    q.delete();
    run_frame(q, 3, "pre_reset_err");
    cmd = 8'h05;
    dat = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      ss_s = 1'b0;
      miso_s = cmd[i];
      @(posedge sclk_s);
      @(negedge sclk_s);
    end
    for (int i = 7; i >= 4; i--) begin
      miso_s = dat[i];
      if (i == 4) rst = 1'b0;
      @(posedge sclk_s);
      @(negedge sclk_s);
    end
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mferr = 1'b0;
    checks++;
    if (busy !== 1'b0 || mosi_s !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b mosi=%b ferr=%b want 0",
               busy, mosi_s, frame_err);
    end
    checks++;
    if (led !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid led: got %h want 0", led);
    end
    rst = 1'b1;
    ss_s = 1'b1;
    miso_s = 1'b0;
    @(posedge sclk_s);
    @(negedge sclk_s);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ferr: got %b want 0", frame_err);
    end
    read_all("reset_mid_regs");
  endtask

  task automatic test_random();
    bq_t q;
    int n;
    int extra;
    logic [3:0] el;
    for (int f = 0; f < 60; f++) begin
      q.delete();
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      for (int j = 0; j < n; j++) q.push_back(8'($urandom));
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(q, extra, "random");
    end
    for (int v = 0; v < 2; v++) begin
      sw = v[0];
      #1;
      el = v[0] ? mreg[0][7:4] : mreg[0][3:0];
      checks++;
      if (led !== el) begin
        errors++;
        $display("FAIL random_led sw=%0d: got %h want %h", v, led, el);
      end
    end
    sw = 1'b0;
    read_all("random_regs");
  endtask

  initial begin
    @(negedge sclk_s);
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_partial();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
